uart_receiver: RTL

Serial receive half of the UART, the counterpart of `uart_transmitter`. It samples the line `RxD` at 16× the selected baud rate and reassembles 11-bit frames: start, 8 data bits LSB first, even parity, stop. It presents the byte on `Rx_DATA` with valid, parity-error and framing-error flags. Runs from the same 50 MHz system clock and the same `baud_select` encoding as the transmitter, so `TxD` can loop straight back into `RxD`.

---
 rtl/uart_receiver.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_receiver.sv
// uart_receiver: serial receive half of the UART.
// Samples RxD at 16x the selected baud rate and reassembles
// start / 8 data (LSB first) / even parity / stop frames.
// Optional build macro: UART_RX_MAJORITY_EN (2-of-3 vote over sc=6,7,8).
//
//   state  | meaning
//   -------+-------------------------------------------------------
//   IDLE   | line idle, waiting for a tick that sees rxd_s low
//   START  | confirming start bit at the sample point (glitch reject)
//   DATA   | shifting 8 data bits into shreg, LSB first
//   PARITY | comparing received parity bit against even parity
//   STOP   | checking stop bit, publishing byte and flags

module uart_receiver #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] baud_select,
  input  logic       Rx_EN,
  input  logic       RxD,
  output logic [7:0] Rx_DATA,
  output logic       Rx_VALID,
  output logic       Rx_PERROR,
  output logic       Rx_FERROR
);

  // The divisor table is fixed and only correct for a 50 MHz clock.
  if (CLK_HZ != 50_000_000) begin : g_clk_warn
    $warning("uart_receiver: divisor table assumes a 50 MHz clock");
  end

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

`ifdef UART_RX_MAJORITY_EN
  localparam logic [3:0] SAMPLE_SC = 4'd8;
`else
  localparam logic [3:0] SAMPLE_SC = 4'd7;
`endif

  logic        rxd_m_q, rxd_s_q;
  logic [13:0] cnt_q, cnt_d;
  logic [13:0] div_m1;
  logic        tick;
  state_t      state_q, state_d;
  logic [3:0]  sc_q, sc_d;
  logic [2:0]  bitcnt_q, bitcnt_d;
  logic [7:0]  shreg_q, shreg_d;
  logic        perr_q, perr_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        perror_q, perror_d;
  logic        ferror_q, ferror_d;
  logic        bit_val;
`ifdef UART_RX_MAJORITY_EN
  logic        s6_q, s6_d, s7_q, s7_d;
`endif

  // Terminal count of the 16x sample-tick divider for each baud code.
  always_comb begin
    case (baud_select)
      3'b000:  div_m1 = 14'd10416;
      3'b001:  div_m1 = 14'd2603;
      3'b010:  div_m1 = 14'd650;
      3'b011:  div_m1 = 14'd325;
      3'b100:  div_m1 = 14'd162;
      3'b101:  div_m1 = 14'd80;
      3'b110:  div_m1 = 14'd53;
      default: div_m1 = 14'd26;
    endcase
  end

  // ">=" lets the divider recover at once if the baud code shrinks while idle.
  assign tick = (cnt_q >= div_m1);

  // Bit decision: single sample, or majority of the two earlier samples and now.
  always_comb begin
`ifdef UART_RX_MAJORITY_EN
    bit_val = (s6_q & s7_q) | (s6_q & rxd_s_q) | (s7_q & rxd_s_q);
`else
    bit_val = rxd_s_q;
`endif
  end

  // Next-state logic for divider, frame FSM, shift register and output flags.
  always_comb begin
    cnt_d    = tick ? 14'd0 : cnt_q + 14'd1;
    state_d  = state_q;
    sc_d     = sc_q;
    bitcnt_d = bitcnt_q;
    shreg_d  = shreg_q;
    perr_d   = perr_q;
    data_d   = data_q;
    valid_d  = valid_q;
    perror_d = perror_q;
    ferror_d = ferror_q;
`ifdef UART_RX_MAJORITY_EN
    s6_d = s6_q;
    s7_d = s7_q;
    if (tick && sc_q == 4'd6) s6_d = rxd_s_q;
    if (tick && sc_q == 4'd7) s7_d = rxd_s_q;
`endif

    if (!Rx_EN) begin
      cnt_d    = 14'd0;
      state_d  = IDLE;
      sc_d     = 4'd0;
      bitcnt_d = 3'd0;
      valid_d  = 1'b0;
      perror_d = 1'b0;
      ferror_d = 1'b0;
    end else if (tick) begin
      sc_d = sc_q + 4'd1;
      case (state_q)
        IDLE: begin
          sc_d = 4'd0;
          if (!rxd_s_q) state_d = START;
        end
        START: begin
          if (sc_q == SAMPLE_SC) begin
            if (bit_val) begin
              state_d = IDLE;
              sc_d    = 4'd0;
            end else begin
              valid_d  = 1'b0;
              perror_d = 1'b0;
              ferror_d = 1'b0;
            end
          end else if (sc_q == 4'd15) begin
            state_d  = DATA;
            bitcnt_d = 3'd0;
          end
        end
        DATA: begin
          if (sc_q == SAMPLE_SC) shreg_d[bitcnt_q] = bit_val;
          if (sc_q == 4'd15) begin
            bitcnt_d = bitcnt_q + 3'd1;
            if (bitcnt_q == 3'd7) state_d = PARITY;
          end
        end
        PARITY: begin
          if (sc_q == SAMPLE_SC) perr_d = bit_val ^ (^shreg_q);
          if (sc_q == 4'd15) state_d = STOP;
        end
        STOP: begin
          if (sc_q == SAMPLE_SC) begin
            data_d   = shreg_q;
            ferror_d = ~bit_val;
            perror_d = perr_q;
            valid_d  = bit_val & ~perr_q;
            // back to IDLE mid-stop-bit so a back-to-back start edge is caught
            state_d  = IDLE;
            sc_d     = 4'd0;
          end
        end
        default: begin
          state_d = IDLE;
          sc_d    = 4'd0;
        end
      endcase
    end
  end

  // All state registers, including the RxD synchronizer, with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      rxd_m_q  <= 1'b1;
      rxd_s_q  <= 1'b1;
      cnt_q    <= 14'd0;
      state_q  <= IDLE;
      sc_q     <= 4'd0;
      bitcnt_q <= 3'd0;
      shreg_q  <= 8'h00;
      perr_q   <= 1'b0;
      data_q   <= 8'h00;
      valid_q  <= 1'b0;
      perror_q <= 1'b0;
      ferror_q <= 1'b0;
`ifdef UART_RX_MAJORITY_EN
      s6_q     <= 1'b1;
      s7_q     <= 1'b1;
`endif
    end else begin
      rxd_m_q  <= RxD;
      rxd_s_q  <= rxd_m_q;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      sc_q     <= sc_d;
      bitcnt_q <= bitcnt_d;
      shreg_q  <= shreg_d;
      perr_q   <= perr_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      perror_q <= perror_d;
      ferror_q <= ferror_d;
`ifdef UART_RX_MAJORITY_EN
      s6_q     <= s6_d;
      s7_q     <= s7_d;
`endif
    end
  end

  assign Rx_DATA   = data_q;
  assign Rx_VALID  = valid_q;
  assign Rx_PERROR = perror_q;
  assign Rx_FERROR = ferror_q;

endmodule
